uart_tx_fifo: RTL and testbench

- Standalone buffered UART transmitter. It accepts bytes through a valid/ready handshake into a small FIFO and serialises them on `tx`.
- Frame format: 8N1 by default, with optional even parity and 1 or 2 stop bits.
- Sits beside the UART receive path, which it never drives. It lets producers queue several bytes without polling `busy` for each byte.
- Frames are sent back-to-back while the FIFO is non-empty.

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a circular FIFO through valid/ready
// and leave back-to-back on tx as 8N1, 8E1, 8N2 or 8E2 frames.
module uart_tx_fifo #(
  parameter int UART_BAUD      = 9600,
  parameter int INPUT_CLOCK    = 50000000,
  parameter int CLOCKS_PER_BIT = INPUT_CLOCK / UART_BAUD,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY_EN      = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int STOP_CYCLES = STOP_BITS * CLOCKS_PER_BIT;
  localparam int CYC_W       = $clog2(STOP_CYCLES);

  localparam logic [CYC_W-1:0] CELL_LAST  = CYC_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] STOP_LAST  = CYC_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] value);
    even_parity = ^value;
  endfunction

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s;
  logic             pop_s;
  logic             fifo_empty_s;

  // ready is registered, so a full FIFO refuses a push even on a pop edge
  assign push_s       = data_in_valid && ready_q;
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});

  // FIFO storage, pointers, occupancy and the flags derived from them
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_COUNT);
    busy_d  = (state_q != S_IDLE) || !fifo_empty_s;
  end

  // Frame sequencer: bit-cell timing, shifting and FIFO pops
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          parity_d = even_parity(mem_q[rd_ptr_q]);
          cyc_d    = {CYC_W{1'b0}};
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cyc_q == CELL_LAST) begin
          cyc_d   = {CYC_W{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == CELL_LAST) begin
          cyc_d   = {CYC_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_PARITY: begin
        if (cyc_q == CELL_LAST) begin
          cyc_d   = {CYC_W{1'b0}};
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STOP: begin
        if (cyc_q == STOP_LAST) begin
          cyc_d = {CYC_W{1'b0}};
          // chaining straight into START keeps frames gap-free
          if (!fifo_empty_s) begin
            pop_s    = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            parity_d = even_parity(mem_q[rd_ptr_q]);
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = {CYC_W{1'b0}};
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level for the current state, registered on the next edge
  always_comb begin
    case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = parity_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset discards queued bytes and any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= {CYC_W{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign data_in_ready = ready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 and 8E2, 16 clocks per bit),
// random bytes, and a mid-bit sampling UART receiver as the reference.
module tb_uart_tx_fifo;

  localparam int CPB = 16;
  localparam int NB0 = 10;
  localparam int NB1 = 12;

  logic       clk  = 1'b0;
  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       ready0, ready1, tx0, tx1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic [11:0] rx0_bits[$], rx1_bits[$];
  int          rx0_start[$], rx1_start[$];
  logic [7:0]  src[$];
  int          push_e[$];
  int          blk_pushed, blk_cnt;

  uart_tx_fifo #(.UART_BAUD(10), .INPUT_CLOCK(160), .FIFO_DEPTH(4),
                 .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst0), .data_in(din0), .data_in_valid(v0),
    .data_in_ready(ready0), .tx(tx0), .busy(busy0), .fifo_count(cnt0));

  uart_tx_fifo #(.UART_BAUD(10), .INPUT_CLOCK(160), .FIFO_DEPTH(4),
                 .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst1), .data_in(din1), .data_in_valid(v1),
    .data_in_ready(ready1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Expected frame as a list of line levels, one per bit cell, start bit first
  function automatic logic [11:0] exp_frame(input logic [7:0] d, input int par_en, input int stops);
    logic [11:0] f;
    int p;
    f = 12'h000;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    p = 9;
    if (par_en != 0) begin
      f[p] = (($countones(d) % 2) == 1);
      p++;
    end
    for (int s = 0; s < stops; s++) begin
      f[p] = 1'b1;
      p++;
    end
    return f;
  endfunction

  // Receivers: detect the falling start edge, then sample each cell mid-way
  initial begin : mon0
    int cnt; bit act; logic prev; logic [11:0] acc; int st;
    cnt = 0; act = 1'b0; prev = 1'b1; acc = 12'h000; st = 0;
    forever begin
      @(negedge clk);
      if (rst0) begin
        act = 1'b0; prev = 1'b1;
      end else begin
        if (!act) begin
          if (prev && tx0 === 1'b0) begin
            act = 1'b1; cnt = 0; acc = 12'h000; st = cyc_n;
          end
        end else begin
          cnt++;
          if (cnt % CPB == CPB / 2) begin
            acc[cnt/CPB] = tx0;
            if (cnt / CPB == NB0 - 1) begin
              rx0_bits.push_back(acc); rx0_start.push_back(st); act = 1'b0;
            end
          end
        end
        prev = tx0;
      end
    end
  end

  initial begin : mon1
    int cnt; bit act; logic prev; logic [11:0] acc; int st;
    cnt = 0; act = 1'b0; prev = 1'b1; acc = 12'h000; st = 0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        act = 1'b0; prev = 1'b1;
      end else begin
        if (!act) begin
          if (prev && tx1 === 1'b0) begin
            act = 1'b1; cnt = 0; acc = 12'h000; st = cyc_n;
          end
        end else begin
          cnt++;
          if (cnt % CPB == CPB / 2) begin
            acc[cnt/CPB] = tx1;
            if (cnt / CPB == NB1 - 1) begin
              rx1_bits.push_back(acc); rx1_start.push_back(st); act = 1'b0;
            end
          end
        end
        prev = tx1;
      end
    end
  end

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin v0 = v; din0 = d; end
    else begin v1 = v; din1 = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (cyc_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds valid on each byte of src until accepted; records push edges
  task automatic stream(input int sel, input int budget);
    int n, t;
    logic rdy;
    logic [2:0] c;
    n = 0; t = 0; blk_pushed = -1; blk_cnt = -1;
    push_e.delete();
    while (n < src.size() && t < budget) begin
      set_in(sel, 1'b1, src[n]);
      @(negedge clk);
      rdy = (sel == 0) ? ready0 : ready1;
      c   = (sel == 0) ? cnt0 : cnt1;
      if (!rdy && blk_pushed < 0) begin
        blk_pushed = n; blk_cnt = int'(c);
      end
      @(posedge clk);
      #1;
      t++;
      if (rdy) begin
        n++;
        push_e.push_back(cyc_n);
      end
    end
    set_in(sel, 1'b0, 8'($urandom));
    if (n < src.size()) begin
      checks++; errors++;
      $display("FAIL stream_timeout: dut%0d accepted %0d, required %0d", sel, n, src.size());
    end
  endtask

  task automatic wait_rx(input int sel, input int n, input int budget);
    int t;
    t = 0;
    while (((sel == 0) ? rx0_bits.size() : rx1_bits.size()) < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (((sel == 0) ? rx0_bits.size() : rx1_bits.size()) < n) begin
      checks++; errors++;
      $display("FAIL rx_timeout: dut%0d frames=%0d, required %0d", sel,
               (sel == 0) ? rx0_bits.size() : rx1_bits.size(), n);
    end
  endtask

  task automatic clear_rx();
    rx0_bits.delete(); rx0_start.delete();
    rx1_bits.delete(); rx1_start.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b%b, required 11", tx0, tx1); end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b, required 00", busy0, busy1); end
    checks++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b%b, required 11", ready0, ready1); end
    checks++;
    if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d/%0d, required 0", cnt0, cnt1); end
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    idle(3);
  endtask

  task automatic test_single();
    int k, d, bad_tx, bad_busy;
    logic [11:0] ef;
    logic etx, ebusy;
    clear_rx();
    src = '{8'hA5};
    stream(0, 20);
    k = (push_e.size() > 0) ? push_e[0] : cyc_n;
    ef = exp_frame(8'hA5, 0, 1);
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 163; i++) begin
      @(negedge clk);
      d = cyc_n - (k + 2);
      etx = (d >= 0 && d < 160) ? ef[d/CPB] : 1'b1;
      ebusy = (d >= -1 && d < 160);
      if (tx0 !== etx) bad_tx++;
      if (busy0 !== ebusy) bad_busy++;
    end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL single_waveform: %0d cycles wrong, required 0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL single_busy: %0d cycles wrong, required 0", bad_busy); end
    wait_rx(0, 1, 50);
    checks++;
    if (rx0_bits.size() != 1 || rx0_bits[0] !== ef) begin
      errors++; $display("FAIL single_rx: got %h, required %h", (rx0_bits.size() > 0) ? rx0_bits[0] : 12'hxxx, ef);
    end
  endtask

  task automatic test_fifo_full();
    int bad, bad_gap;
    idle(20);
    clear_rx();
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    stream(0, 300);
    checks++;
    if (blk_pushed != 5) begin errors++; $display("FAIL full_when: ready fell after %0d pushes, required 5", blk_pushed); end
    checks++;
    if (blk_cnt != 4) begin errors++; $display("FAIL full_count: fifo_count=%0d at ready low, required 4", blk_cnt); end
    wait_rx(0, 6, 1400);
    bad = 0; bad_gap = 0;
    for (int i = 0; i < 6 && i < rx0_bits.size(); i++) begin
      if (rx0_bits[i] !== exp_frame(src[i], 0, 1)) bad++;
      if (i > 0 && rx0_start[i] - rx0_start[i-1] != 160) bad_gap++;
    end
    checks++;
    if (bad != 0 || rx0_bits.size() != 6) begin errors++; $display("FAIL full_order: %0d frames wrong of %0d, required 0 of 6", bad, rx0_bits.size()); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL full_back_to_back: %0d gaps not 160, required 0", bad_gap); end
    checks++;
    if (rx0_start.size() == 0 || rx0_start[0] != push_e[0] + 2) begin
      errors++; $display("FAIL full_latency: start at %0d, required %0d", (rx0_start.size() > 0) ? rx0_start[0] : -1, push_e[0] + 2);
    end
  endtask

  task automatic test_simultaneous();
    int k, bad, cb, ca;
    logic [7:0] d3;
    logic [7:0] all[$];
    idle(20);
    clear_rx();
    src = '{8'($urandom), 8'($urandom), 8'($urandom)};
    all = src;
    d3 = 8'($urandom);
    all.push_back(d3);
    stream(0, 20);
    k = push_e[0];
    wait_edge(k + 160);
    set_in(0, 1'b1, d3);
    @(negedge clk);
    cb = int'(cnt0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, ~d3);
    @(negedge clk);
    ca = int'(cnt0);
    checks++;
    if (cb != 2) begin errors++; $display("FAIL simul_before: fifo_count=%0d, required 2", cb); end
    checks++;
    if (ca != 2) begin errors++; $display("FAIL simul_after: fifo_count=%0d, required 2", ca); end
    wait_rx(0, 4, 700);
    bad = 0;
    for (int i = 0; i < 4 && i < rx0_bits.size(); i++) begin
      if (rx0_bits[i] !== exp_frame(all[i], 0, 1)) bad++;
      if (i > 0 && rx0_start[i] - rx0_start[i-1] != 160) bad++;
    end
    checks++;
    if (bad != 0 || rx0_bits.size() != 4) begin errors++; $display("FAIL simul_order: %0d errors in %0d frames, required 0 in 4", bad, rx0_bits.size()); end
  endtask

  task automatic test_reset_mid();
    int f, bad;
    idle(20);
    clear_rx();
    src = '{8'($urandom), 8'($urandom), 8'($urandom)};
    stream(0, 20);
    f = push_e[0] + 2;
    wait_edge(f + 70);
    rst0 = 1'b1;
    #2;
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b, required 1", tx0); end
    checks++;
    if (cnt0 !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d, required 0", cnt0); end
    checks++;
    if (busy0 !== 1'b0 || ready0 !== 1'b1) begin errors++; $display("FAIL rstmid_flags: busy=%b ready=%b, required 0 1", busy0, ready0); end
    #8;
    rst0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles, required 0", bad); end
    checks++;
    if (rx0_bits.size() != 0) begin errors++; $display("FAIL rstmid_frames: %0d frames, required 0", rx0_bits.size()); end
  endtask

  task automatic test_wrap();
    int bad;
    logic [7:0] all[$];
    idle(20);
    clear_rx();
    all.delete();
    for (int g = 0; g < 3; g++) begin
      src = '{8'($urandom), 8'($urandom), 8'($urandom)};
      foreach (src[j]) all.push_back(src[j]);
      stream(0, 50);
      wait_rx(0, 3 * (g + 1), 700);
      idle($urandom_range(0, 30));
    end
    bad = 0;
    for (int i = 0; i < 9 && i < rx0_bits.size(); i++) begin
      if (rx0_bits[i] !== exp_frame(all[i], 0, 1)) bad++;
    end
    checks++;
    if (bad != 0 || rx0_bits.size() != 9) begin errors++; $display("FAIL wrap_data: %0d wrong of %0d, required 0 of 9", bad, rx0_bits.size()); end
  endtask

  task automatic test_parity();
    int bad;
    idle(5);
    clear_rx();
    src = '{8'h07, 8'h03};
    stream(1, 20);
    wait_rx(1, 2, 600);
    checks++;
    if (rx1_bits.size() < 2 || rx1_bits[0][9] !== 1'b1) begin errors++; $display("FAIL parity_07: parity cell wrong, required 1"); end
    checks++;
    if (rx1_bits.size() < 2 || rx1_bits[1][9] !== 1'b0) begin errors++; $display("FAIL parity_03: parity cell wrong, required 0"); end
    checks++;
    if (rx1_bits.size() < 2 || rx1_bits[0] !== exp_frame(8'h07, 1, 2) || rx1_bits[1] !== exp_frame(8'h03, 1, 2)) begin
      errors++; $display("FAIL parity_frames: got %h %h, required %h %h",
        (rx1_bits.size() > 0) ? rx1_bits[0] : 12'hxxx, (rx1_bits.size() > 1) ? rx1_bits[1] : 12'hxxx,
        exp_frame(8'h07, 1, 2), exp_frame(8'h03, 1, 2));
    end
    checks++;
    if (rx1_start.size() < 2 || rx1_start[1] - rx1_start[0] != 192) begin
      errors++; $display("FAIL parity_length: frame spacing %0d, required 192", (rx1_start.size() > 1) ? rx1_start[1] - rx1_start[0] : -1);
    end
    idle(30);
    clear_rx();
    src = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    stream(1, 20);
    wait_rx(1, 4, 1000);
    bad = 0;
    for (int i = 0; i < 4 && i < rx1_bits.size(); i++) begin
      if (rx1_bits[i] !== exp_frame(src[i], 1, 2)) bad++;
    end
    checks++;
    if (bad != 0 || rx1_bits.size() != 4) begin errors++; $display("FAIL parity_random: %0d wrong of %0d, required 0 of 4", bad, rx1_bits.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
